// File: rtl/regfile_pkg.sv
// regfile_pkg: shared register-file / scoreboard constants and types.
// No ports; imported by the scoreboard and its counter.
package regfile_pkg;

  localparam int NUM_REGS = 32;
  localparam int ADDR_W   = $clog2(NUM_REGS);
  localparam int CNT_W    = 2;
  localparam int REG_ZERO = 0;

  typedef logic [ADDR_W-1:0] reg_addr_t;
  typedef logic [CNT_W-1:0]  sb_cnt_t;

endpackage

// File: rtl/sb_counter.sv
// sb_counter: saturating up/down pending-write counter for one register.
// Ports: clk, reset, inc, dec, clr -> count, nonzero, full, underflow.
module sb_counter
  import regfile_pkg::*;
#(
  parameter int W = CNT_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  input  logic         dec,
  input  logic         clr,
  output logic [W-1:0] count,
  output logic         nonzero,
  output logic         full,
  output logic         underflow
);

  logic [W-1:0] cnt_q, cnt_d;

  assign count   = cnt_q;
  assign nonzero = (cnt_q != '0);
  assign full    = (cnt_q == '1);

  // inc and dec together cancel, so they never flag underflow.
  assign underflow = dec && !inc
                  && !nonzero && !clr;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && !dec && !full) begin
      cnt_d = cnt_q + W'(1);
    end else if (dec && !inc && nonzero) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/reg_scoreboard.sv
// reg_scoreboard: issue-side pending-write tracker, stalls RAW hazards.
// Ports: issue_* / wb_* / flush in; stall_rs*, issue_ready, pending_any,
// err_underflow out. Define WB_BYPASS_EN to release stalls on same-cycle wb.
module reg_scoreboard
  import regfile_pkg::*;
#(
  parameter int NUM_REGS = regfile_pkg::NUM_REGS,
  parameter int ADDR_W   = regfile_pkg::ADDR_W,
  parameter int CNT_W    = regfile_pkg::CNT_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              issue_valid,
  output logic              issue_ready,
  input  logic [ADDR_W-1:0] issue_rs1,
  input  logic [ADDR_W-1:0] issue_rs2,
  input  logic [ADDR_W-1:0] issue_rd,
  input  logic              issue_wr,
  input  logic              wb_valid,
  input  logic [ADDR_W-1:0] wb_rd,
  input  logic              flush,
  output logic              stall_rs1,
  output logic              stall_rs2,
  output logic              pending_any,
  output logic              err_underflow
);

  logic [CNT_W-1:0]    cnt [NUM_REGS];
  logic [NUM_REGS-1:0] nz, full, uf;
  logic                inc_en, err_q, err_d;
  logic                byp1, byp2;

  // Register 0 is never pending.
  assign cnt[0]  = '0;
  assign nz[0]   = 1'b0;
  assign full[0] = 1'b0;
  assign uf[0]   = 1'b0;

  assign inc_en = issue_valid && issue_ready
               && issue_wr
               && (issue_rd != ADDR_W'(REG_ZERO));

  for (genvar i = 1; i < NUM_REGS; i++) begin : g_cnt
    logic inc, dec;
    assign inc = inc_en && (issue_rd == ADDR_W'(i));
    assign dec = wb_valid && (wb_rd == ADDR_W'(i));

    sb_counter #(.W(CNT_W)) u_cnt (
      .clk       (clk),
      .reset     (reset),
      .inc       (inc),
      .dec       (dec),
      .clr       (flush),
      .count     (cnt[i]),
      .nonzero   (nz[i]),
      .full      (full[i]),
      .underflow (uf[i])
    );
  end

`ifdef WB_BYPASS_EN
  // Last outstanding write retiring now: regfile writes before read.
  assign byp1 = wb_valid && (wb_rd == issue_rs1)
             && (cnt[issue_rs1] == CNT_W'(1));
  assign byp2 = wb_valid && (wb_rd == issue_rs2)
             && (cnt[issue_rs2] == CNT_W'(1));
`else
  assign byp1 = 1'b0;
  assign byp2 = 1'b0;
`endif

  assign stall_rs1 = nz[issue_rs1] && !byp1;
  assign stall_rs2 = nz[issue_rs2] && !byp2;

  assign issue_ready = !stall_rs1 && !stall_rs2
                    && !(issue_wr && full[issue_rd]);

  assign pending_any   = |nz;
  assign err_underflow = err_q;

  assign err_d = err_q || (|uf);

  always_ff @(posedge clk) begin
    if (reset) err_q <= 1'b0;
    else       err_q <= err_d;
  end

endmodule

// File: tb/tb_reg_scoreboard.sv
// tb_reg_scoreboard: scoreboard bench for reg_scoreboard.
// Model-driven expectations queued per cycle plus directed scenario checks.
module tb_reg_scoreboard;

  logic       clk = 1'b0;
  logic       reset;
  logic       issue_valid, issue_ready;
  logic [4:0] issue_rs1, issue_rs2, issue_rd;
  logic       issue_wr;
  logic       wb_valid;
  logic [4:0] wb_rd;
  logic       flush;
  logic       stall_rs1, stall_rs2;
  logic       pending_any, err_underflow;

  always #5 clk = ~clk;

  reg_scoreboard dut (
    .clk           (clk),
    .reset         (reset),
    .issue_valid   (issue_valid),
    .issue_ready   (issue_ready),
    .issue_rs1     (issue_rs1),
    .issue_rs2     (issue_rs2),
    .issue_rd      (issue_rd),
    .issue_wr      (issue_wr),
    .wb_valid      (wb_valid),
    .wb_rd         (wb_rd),
    .flush         (flush),
    .stall_rs1     (stall_rs1),
    .stall_rs2     (stall_rs2),
    .pending_any   (pending_any),
    .err_underflow (err_underflow)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic s1, s2, rdy, pend, err;
  } exp_t;

  exp_t q[$];
  int   mcnt [32];
  bit   merr;

  function automatic bit mstall(int rs, bit wbv, int wbrd);
    bit s;
    if (rs == 0) return 1'b0;
    s = (mcnt[rs] != 0);
`ifdef WB_BYPASS_EN
    if (wbv && wbrd == rs && mcnt[rs] == 1) s = 1'b0;
`endif
    return s;
  endfunction

  task automatic cyc(input bit iv, input int rs1, input int rs2,
                     input int rd, input bit wr,
                     input bit wbv, input int wbrd,
                     input bit fl, input bit rst);
    exp_t e, o;
    bit   any, inc, ret;
    @(negedge clk);
    issue_valid = iv;
    issue_rs1   = 5'(rs1);
    issue_rs2   = 5'(rs2);
    issue_rd    = 5'(rd);
    issue_wr    = wr;
    wb_valid    = wbv;
    wb_rd       = 5'(wbrd);
    flush       = fl;
    reset       = rst;
    any = 1'b0;
    for (int i = 1; i < 32; i++) if (mcnt[i] != 0) any = 1'b1;
    e.s1   = mstall(rs1, wbv, wbrd);
    e.s2   = mstall(rs2, wbv, wbrd);
    e.rdy  = !e.s1 && !e.s2 && !(wr && rd != 0 && mcnt[rd] == 3);
    e.pend = any;
    e.err  = merr;
    q.push_back(e);
    #2;
    o = q.pop_front();
    chk("stall_rs1", stall_rs1, o.s1);
    chk("stall_rs2", stall_rs2, o.s2);
    chk("issue_ready", issue_ready, o.rdy);
    chk("pending_any", pending_any, o.pend);
    chk("err_underflow", err_underflow, o.err);
    // Next-state of the reference model.
    if (rst) begin
      for (int i = 0; i < 32; i++) mcnt[i] = 0;
      merr = 1'b0;
    end else if (fl) begin
      for (int i = 0; i < 32; i++) mcnt[i] = 0;
    end else begin
      inc = iv && o.rdy && wr && rd != 0;
      ret = wbv && wbrd != 0;
      if (!(inc && ret && rd == wbrd)) begin
        if (inc && mcnt[rd] < 3) mcnt[rd]++;
        if (ret) begin
          if (mcnt[wbrd] > 0) mcnt[wbrd]--;
          else merr = 1'b1;
        end
      end
    end
  endtask

  task automatic idle(input int rs1, input int rs2);
    cyc(0, rs1, rs2, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) mcnt[i] = 0;
    merr        = 1'b0;
    reset       = 1'b1;
    issue_valid = 1'b0;
    issue_rs1   = '0;
    issue_rs2   = '0;
    issue_rd    = '0;
    issue_wr    = 1'b0;
    wb_valid    = 1'b0;
    wb_rd       = '0;
    flush       = 1'b0;
    repeat (2) @(posedge clk);

    // Reset state.
    idle(0, 0);
    chk("rst_ready", issue_ready, 1);
    chk("rst_pend", pending_any, 0);
    chk("rst_err", err_underflow, 0);

    // RAW hazard on x15.
    cyc(1, 0, 0, 15, 1, 0, 0, 0, 0);
    idle(15, 0);
    chk("raw_stall", stall_rs1, 1);
    chk("raw_ready", issue_ready, 0);
    cyc(0, 15, 0, 0, 0, 1, 15, 0, 0);
`ifdef WB_BYPASS_EN
    chk("raw_byp", stall_rs1, 0);
`else
    chk("raw_wbcyc", stall_rs1, 1);
`endif
    idle(15, 0);
    chk("raw_clear", stall_rs1, 0);

    // Register 0.
    cyc(1, 0, 0, 0, 1, 0, 0, 0, 0);
    idle(0, 0);
    chk("x0_stall", stall_rs1 | stall_rs2, 0);
    chk("x0_pend", pending_any, 0);
    cyc(0, 0, 0, 0, 0, 1, 0, 0, 0);
    idle(0, 0);
    chk("x0_err", err_underflow, 0);

    // Saturation on x16.
    repeat (3) cyc(1, 0, 0, 16, 1, 0, 0, 0, 0);
    cyc(1, 0, 0, 16, 1, 0, 0, 0, 0);
    chk("sat_ready", issue_ready, 0);
    cyc(0, 0, 0, 16, 1, 1, 16, 0, 0);
    cyc(0, 0, 0, 16, 1, 0, 0, 0, 0);
    chk("sat_release", issue_ready, 1);

    // Simultaneous fire and retire on x5.
    cyc(1, 0, 0, 5, 1, 0, 0, 0, 0);
    cyc(1, 0, 0, 5, 1, 1, 5, 0, 0);
    idle(5, 0);
    chk("simul_stall", stall_rs1, 1);
    chk("simul_err", err_underflow, 0);

    // Underflow on x10.
    cyc(0, 0, 0, 0, 0, 1, 10, 0, 0);
    idle(0, 0);
    chk("uf_set", err_underflow, 1);
    idle(0, 0);
    chk("uf_sticky", err_underflow, 1);

    // Flush with x5 and x15 pending.
    cyc(1, 0, 0, 15, 1, 0, 0, 0, 0);
    cyc(1, 0, 0, 7, 1, 1, 5, 1, 0);
    idle(5, 15);
    chk("fl_pend", pending_any, 0);
    chk("fl_err", err_underflow, 1);

    // Random traffic on a few registers.
    for (int n = 0; n < 300; n++) begin
      cyc($urandom_range(0, 1), $urandom_range(0, 3),
          $urandom_range(0, 3), $urandom_range(0, 3),
          $urandom_range(0, 1), $urandom_range(0, 1),
          $urandom_range(0, 3),
          ($urandom_range(0, 19) == 0),
          ($urandom_range(0, 59) == 0));
    end

    // Reset mid-run.
    cyc(0, 0, 0, 0, 0, 1, 9, 0, 0);
    cyc(1, 0, 0, 3, 1, 0, 0, 0, 1);
    idle(3, 0);
    chk("rst_mid_err", err_underflow, 0);
    chk("rst_mid_pend", pending_any, 0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/reg_scoreboard.md
Name: reg_scoreboard

Overview:
- Tracks in-flight register writes for the pipelined processor; this is the issue-side counterpart of the register file's write port.
- Decode presents source/destination register numbers; the block stalls issue while any source has an outstanding write.
- Writeback retires pending writes using the same rd/RegWrite information that drives the register file.
- Register 0 is never pending.

Parameters:
- NUM_REGS, 32, number of architectural registers.
- ADDR_W, 5, register address width; clog2(NUM_REGS).
- CNT_W, 2, per-register pending-counter width; max outstanding writes per register = 2^CNT_W-1.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- issue_valid  input  1  decode has an instruction to issue.
- issue_ready  output  1  instruction may issue this cycle.
- issue_rs1  input  ADDR_W  source register 1.
- issue_rs2  input  ADDR_W  source register 2.
- issue_rd  input  ADDR_W  destination register.
- issue_wr  input  1  instruction writes issue_rd (RegWrite of issuing instruction).
- wb_valid  input  1  writeback RegWrite this cycle.
- wb_rd  input  ADDR_W  writeback destination (writereg).
- flush  input  1  discard all pending state (pipeline squash).
- stall_rs1  output  1  rs1 has an outstanding write.
- stall_rs2  output  1  rs2 has an outstanding write.
- pending_any  output  1  any register count nonzero.
- err_underflow  output  1  sticky: writeback to a register with count 0.

Behaviour:
- Single clock domain: reset is synchronous and active-high; clk rising edge, reset port named reset.
- State: one CNT_W counter per register 1..NUM_REGS-1; register 0 is hardwired 0.
- Reset: all counters 0, err_underflow 0. Combinational outputs follow, giving stall_rs1=0, stall_rs2=0, pending_any=0, issue_ready=1.
- stall_rsN = (cnt[issue_rsN] != 0). Combinational; 0 for register 0.
- issue_ready = !stall_rs1 && !stall_rs2 && !(issue_wr && issue_rd!=0 && cnt[issue_rd]==max).
- issue_ready does not depend on issue_valid.
- Issue fire = issue_valid && issue_ready.
  - On fire with issue_wr=1 and issue_rd!=0: cnt[issue_rd] += 1 at the next edge.
- Retire = wb_valid && wb_rd!=0.
  - If cnt[wb_rd] > 0: decrement.
  - If cnt[wb_rd] == 0: count stays 0 and err_underflow sets to 1 (sticky until reset).
- Fire-increment and retire to the same register in the same cycle: net count unchanged; no underflow flagged even when the count is 0.
- Fire-increment and retire to different registers: both apply.
- wb_valid with wb_rd=0: ignored; never flags an error.
- Saturation: counter never wraps; issue is blocked by issue_ready instead.
- flush: all counters cleared at the next edge; issue and retire in that cycle are ignored; err_underflow is preserved.
- Priority: reset > flush > issue/retire.
- Reset asserted mid-operation clears everything in one cycle; outputs are valid the following cycle.
- Latency:
  - An issue affects stall outputs one cycle after the fire edge.
  - A retire clears a stall one cycle after the wb edge (baseline).

Optional Feature:
- Macro: WB_BYPASS_EN.
- Defined: stall_rsN is additionally masked when wb_valid && wb_rd==issue_rsN && cnt[issue_rsN]==1. The same-cycle writeback releases the stall, matching register-file write-before-read. issue_ready follows the masked stalls.
- Undefined: no bypass; stall releases the cycle after retire.

Decomposition:
- Package regfile_pkg:
  - constants NUM_REGS, ADDR_W, REG_ZERO=0.
  - typedef reg_addr_t (ADDR_W bits).
  - typedef sb_cnt_t (CNT_W bits).
- Sub-module sb_counter:
  - One saturating up/down counter with inc, dec and clr inputs.
  - Outputs nonzero, full and underflow.
  - Instantiated per register 1..NUM_REGS-1.

Test Plan:
- Reset: assert reset 2 cycles -> stall_rs1=0, stall_rs2=0, pending_any=0, issue_ready=1, err_underflow=0.
- Basic RAW hazard:
  - Issue rd=15, wr=1; next cycle rs1=15 -> stall_rs1=1, issue_ready=0.
  - wb_valid, wb_rd=15 -> stall clears the next cycle (same cycle with WB_BYPASS_EN).
- Register 0: issue rd=0, wr=1, then rs1=0, rs2=0 -> no stall. wb_rd=0 -> err_underflow stays 0.
- Saturation:
  - Three issues to rd=16 with no retire -> cnt=3. A 4th issue to rd=16 -> issue_ready=0.
  - One wb to 16 -> issue_ready=1.
- Simultaneous events and underflow:
  - Fire rd=5 and wb_rd=5 with cnt[5]=1 -> cnt stays 1.
  - wb_rd=10 with cnt[10]=0 -> err_underflow=1 and stays 1.
- Flush/reset mid-operation:
  - Pending on 5 and 15; flush with wb_rd=5 -> all counts 0, pending_any=0, err_underflow unchanged.
  - reset mid-run -> err_underflow=0.
